spec_branch_tracker: RTL and testbench

Tracks in-flight speculative branches in program order and generates the per-branch event stream consumed by the speculative load fence counter. Emits one `fence_o` pulse per accepted branch dispatch and one `retire_branch_o` pulse per branch leaving the tracker, including branches squashed by a mispredict. Every fence is therefore matched by exactly one retire. Sits between dispatch/branch-resolution logic and the load fence unit in the security path.

---
 rtl/spec_branch_tracker_if.sv | 44 ++++
 rtl/spec_branch_tracker.sv | 119 +++++++++++
 tb/tb_spec_branch_tracker.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/spec_branch_tracker_if.sv
// Bus between dispatch/branch-resolution logic and the speculative branch tracker.
// The master side issues dispatches and resolves; the slave side is the tracker,
// which returns dispatch handshake information and the fence/retire event stream.
interface spec_branch_tracker_if #(
   parameter int DEPTH = 8,
   parameter int TAG_W = $clog2(DEPTH)
);
   logic             dispatch_valid_i;
   logic             dispatch_ready_o;
   logic [TAG_W-1:0] dispatch_tag_o;
   logic             resolve_valid_i;
   logic [TAG_W-1:0] resolve_tag_i;
   logic             resolve_mispredict_i;
   logic             fence_o;
   logic             retire_branch_o;
   logic             retire_squashed_o;
   logic [TAG_W:0]   count_o;

   modport master (
      output dispatch_valid_i,
      input  dispatch_ready_o,
      input  dispatch_tag_o,
      output resolve_valid_i,
      output resolve_tag_i,
      output resolve_mispredict_i,
      input  fence_o,
      input  retire_branch_o,
      input  retire_squashed_o,
      input  count_o
   );

   modport slave (
      input  dispatch_valid_i,
      output dispatch_ready_o,
      output dispatch_tag_o,
      input  resolve_valid_i,
      input  resolve_tag_i,
      input  resolve_mispredict_i,
      output fence_o,
      output retire_branch_o,
      output retire_squashed_o,
      output count_o
   );
endinterface

// File: rtl/spec_branch_tracker.sv
// Speculative branch tracker: a circular buffer of in-flight branches kept in
// program order. Each accepted dispatch produces one fence pulse and each entry
// leaving the buffer (resolved or squashed) produces one retire pulse, so the
// downstream load fence counter always sees matched fence/retire events.
module spec_branch_tracker #(
   parameter int DEPTH = 8,
   parameter int TAG_W = $clog2(DEPTH)
) (
   input logic                  clk,
   input logic                  rst_n,
   spec_branch_tracker_if.slave bus
);

   localparam logic [TAG_W:0] FULL_COUNT = (TAG_W+1)'(DEPTH);

   logic [DEPTH-1:0] valid_q, valid_d;
   logic [DEPTH-1:0] resolved_q, resolved_d;
   logic [DEPTH-1:0] squashed_q, squashed_d;
   logic [TAG_W-1:0] head_q, head_d;
   logic [TAG_W-1:0] tail_q, tail_d;
   logic [TAG_W:0]   count_q, count_d;
   logic             fence_q, fence_d;
   logic             retire_q, retire_d;
   logic             retire_sq_q, retire_sq_d;

   logic             ready;
   logic             acc;
   logic             res_hit;
   logic             mispredict;
   logic             pop;
   logic [TAG_W-1:0] res_age;

   // Per-cycle decisions; dispatch wins over retire so fence and retire never coincide
   always_comb begin
      ready      = (count_q < FULL_COUNT);
      acc        = bus.dispatch_valid_i && ready;
      res_hit    = bus.resolve_valid_i && valid_q[bus.resolve_tag_i] && !resolved_q[bus.resolve_tag_i];
      mispredict = res_hit && bus.resolve_mispredict_i;
      res_age    = bus.resolve_tag_i - head_q;
      pop        = valid_q[head_q] && resolved_q[head_q] && !acc;
   end

   // Next-state of the entry array, pointers, occupancy and event pulses
   always_comb begin
      logic [TAG_W-1:0] age;
      age         = '0;
      valid_d     = valid_q;
      resolved_d  = resolved_q;
      squashed_d  = squashed_q;
      head_d      = head_q;
      tail_d      = tail_q;

      if (res_hit) begin
         resolved_d[bus.resolve_tag_i] = 1'b1;
      end

      if (mispredict) begin
         for (int i = 0; i < DEPTH; i++) begin
            age = TAG_W'(i) - head_q;
            if (valid_q[i] && (age > res_age)) begin
               resolved_d[i] = 1'b1;
               squashed_d[i] = 1'b1;
            end
         end
      end

      if (acc) begin
         valid_d[tail_q]    = 1'b1;
         resolved_d[tail_q] = mispredict;
         squashed_d[tail_q] = mispredict;
         tail_d             = tail_q + TAG_W'(1);
      end

      if (pop) begin
         valid_d[head_q]    = 1'b0;
         resolved_d[head_q] = 1'b0;
         squashed_d[head_q] = 1'b0;
         head_d             = head_q + TAG_W'(1);
      end

      count_d     = count_q + (TAG_W+1)'(acc) - (TAG_W+1)'(pop);
      fence_d     = acc;
      retire_d    = pop;
      retire_sq_d = pop && squashed_q[head_q];
   end

   // State registers; reset discards all entries and any pending pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q     <= '0;
         resolved_q  <= '0;
         squashed_q  <= '0;
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         fence_q     <= 1'b0;
         retire_q    <= 1'b0;
         retire_sq_q <= 1'b0;
      end else begin
         valid_q     <= valid_d;
         resolved_q  <= resolved_d;
         squashed_q  <= squashed_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         fence_q     <= fence_d;
         retire_q    <= retire_d;
         retire_sq_q <= retire_sq_d;
      end
   end

   assign bus.dispatch_ready_o  = ready;
   assign bus.dispatch_tag_o    = tail_q;
   assign bus.fence_o           = fence_q;
   assign bus.retire_branch_o   = retire_q;
   assign bus.retire_squashed_o = retire_sq_q;
   assign bus.count_o           = count_q;

endmodule

// File: tb/tb_spec_branch_tracker.sv
// Directed bench for spec_branch_tracker. Expected retire squash bits are queued
// when the stimulus that causes them is driven and checked as retire pulses appear.
module tb_spec_branch_tracker;

   localparam int DEPTH = 8;
   localparam int TAG_W = 3;

   logic clk = 1'b0;
   logic rst_n;

   spec_branch_tracker_if #(.DEPTH(DEPTH)) bus ();

   spec_branch_tracker #(.DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int fenceCount = 0;
   int retireCount = 0;
   bit expQ[$];
   logic [TAG_W-1:0] nextTag;
   logic [TAG_W-1:0] baseTag;
   int fenceStart;
   int retireStart;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic dv, input logic rv,
                                input logic [TAG_W-1:0] rtag, input logic rmis);
      bus.dispatch_valid_i     = dv;
      bus.resolve_valid_i      = rv;
      bus.resolve_tag_i        = rtag;
      bus.resolve_mispredict_i = rmis;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", name, observed, expected);
      end
   endtask

   task automatic checkResetOutputs(input string pfx);
      checkOutput({pfx, "_fence"}, 32'(bus.fence_o), 0);
      checkOutput({pfx, "_retire"}, 32'(bus.retire_branch_o), 0);
      checkOutput({pfx, "_squashed"}, 32'(bus.retire_squashed_o), 0);
      checkOutput({pfx, "_count"}, 32'(bus.count_o), 0);
      checkOutput({pfx, "_ready"}, 32'(bus.dispatch_ready_o), 1);
      checkOutput({pfx, "_tag"}, 32'(bus.dispatch_tag_o), 0);
   endtask

   task automatic waitDrain(input string name);
      for (int i = 0; i < 64 && bus.count_o != 0; i++) tick();
      checkOutput(name, 32'(bus.count_o), 0);
   endtask

   // Event monitor: exclusivity every cycle, squash bits checked against the scoreboard
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         checkOutput("fence_retire_exclusive", 32'(bus.fence_o & bus.retire_branch_o), 0);
         if (bus.fence_o) fenceCount++;
         if (bus.retire_branch_o) begin
            retireCount++;
            total++;
            assert (expQ.size() > 0)
            else begin
               bad++;
               $error("[TB] FAIL retire_unexpected observed=1 expected=0");
            end
            if (expQ.size() > 0) checkOutput("retire_squashed", 32'(bus.retire_squashed_o), 32'(expQ.pop_front()));
         end
      end
   end

   // Global time limit so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL timeout observed=running expected=finished");
      $fatal(1, "[TB] time limit reached");
   end

   // Directed sequence
   initial begin
      applyStimulus(1'b0, 1'b0, '0, 1'b0);
      rst_n = 1'b0;
      #1;
      checkResetOutputs("reset_async");
      repeat (2) tick();
      checkResetOutputs("reset");
      rst_n = 1'b1;
      nextTag = '0;

      // Single branch through dispatch, resolve and retire
      applyStimulus(1'b1, 1'b0, '0, 1'b0);
      checkOutput("t1_ready", 32'(bus.dispatch_ready_o), 1);
      checkOutput("t1_tag", 32'(bus.dispatch_tag_o), 0);
      tick();
      applyStimulus(1'b0, 1'b0, '0, 1'b0);
      nextTag++;
      checkOutput("t1_fence", 32'(bus.fence_o), 1);
      checkOutput("t1_count", 32'(bus.count_o), 1);
      repeat (2) tick();
      applyStimulus(1'b0, 1'b1, 3'd0, 1'b0);
      expQ.push_back(1'b0);
      tick();
      applyStimulus(1'b0, 1'b0, '0, 1'b0);
      checkOutput("t1_no_early_retire", 32'(bus.retire_branch_o), 0);
      tick();
      checkOutput("t1_retire", 32'(bus.retire_branch_o), 1);
      checkOutput("t1_count_after", 32'(bus.count_o), 0);
      tick();
      checkOutput("t1_retire_single", 32'(bus.retire_branch_o), 0);

      // Fill to DEPTH with wrapping tags, then free one slot via resolve
      baseTag = nextTag;
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(1'b1, 1'b0, '0, 1'b0);
         checkOutput("fill_tag", 32'(bus.dispatch_tag_o), 32'(nextTag));
         nextTag++;
         tick();
      end
      checkOutput("full_ready", 32'(bus.dispatch_ready_o), 0);
      checkOutput("full_count", 32'(bus.count_o), DEPTH);
      tick();
      checkOutput("full_blocked_fence", 32'(bus.fence_o), 0);
      checkOutput("full_blocked_count", 32'(bus.count_o), DEPTH);
      applyStimulus(1'b1, 1'b1, baseTag, 1'b0);
      expQ.push_back(1'b0);
      tick();
      applyStimulus(1'b1, 1'b0, '0, 1'b0);
      checkOutput("full_still_blocked", 32'(bus.dispatch_ready_o), 0);
      tick();
      checkOutput("full_pop_retire", 32'(bus.retire_branch_o), 1);
      checkOutput("full_pop_count", 32'(bus.count_o), DEPTH - 1);
      checkOutput("full_ready_again", 32'(bus.dispatch_ready_o), 1);
      checkOutput("full_reuse_tag", 32'(bus.dispatch_tag_o), 32'(nextTag));
      tick();
      applyStimulus(1'b0, 1'b0, '0, 1'b0);
      nextTag++;
      checkOutput("full_reuse_fence", 32'(bus.fence_o), 1);
      checkOutput("full_refill_count", 32'(bus.count_o), DEPTH);
      baseTag = baseTag + 3'd1;
      for (int k = 0; k < DEPTH; k++) begin
         applyStimulus(1'b0, 1'b1, baseTag + TAG_W'(k), 1'b0);
         expQ.push_back(1'b0);
         tick();
      end
      applyStimulus(1'b0, 1'b0, '0, 1'b0);
      waitDrain("fill_drain");

      // Out-of-order resolve: nothing retires until the oldest resolves
      baseTag = nextTag;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1'b0, '0, 1'b0);
         tick();
      end
      nextTag = nextTag + 3'd3;
      applyStimulus(1'b0, 1'b1, baseTag + 3'd2, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b1, baseTag + 3'd1, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0, '0, 1'b0);
      tick();
      checkOutput("ooo_hold_a", 32'(bus.retire_branch_o), 0);
      tick();
      checkOutput("ooo_hold_b", 32'(bus.retire_branch_o), 0);
      checkOutput("ooo_hold_count", 32'(bus.count_o), 3);
      repeat (3) expQ.push_back(1'b0);
      applyStimulus(1'b0, 1'b1, baseTag, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0, '0, 1'b0);
      checkOutput("ooo_latency", 32'(bus.retire_branch_o), 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("ooo_burst", 32'(bus.retire_branch_o), 1);
      end
      tick();
      checkOutput("ooo_burst_end", 32'(bus.retire_branch_o), 0);
      checkOutput("ooo_count", 32'(bus.count_o), 0);

      // Mispredict squashes younger entries and a same-cycle dispatch
      baseTag = nextTag;
      fenceStart = fenceCount;
      retireStart = retireCount;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 1'b0, '0, 1'b0);
         tick();
      end
      nextTag = nextTag + 3'd5;
      applyStimulus(1'b1, 1'b1, baseTag + 3'd1, 1'b1);
      checkOutput("mp_tag", 32'(bus.dispatch_tag_o), 32'(TAG_W'(baseTag + 3'd5)));
      expQ.push_back(1'b0);
      expQ.push_back(1'b0);
      repeat (4) expQ.push_back(1'b1);
      tick();
      nextTag++;
      applyStimulus(1'b0, 1'b0, '0, 1'b0);
      checkOutput("mp_count", 32'(bus.count_o), 6);
      repeat (3) tick();
      checkOutput("mp_blocked", 32'(bus.retire_branch_o), 0);
      applyStimulus(1'b0, 1'b1, baseTag, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0, '0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         tick();
         checkOutput("mp_retire", 32'(bus.retire_branch_o), 1);
      end
      tick();
      checkOutput("mp_retire_end", 32'(bus.retire_branch_o), 0);
      checkOutput("mp_count_after", 32'(bus.count_o), 0);
      checkOutput("mp_fence_total", 32'(fenceCount - fenceStart), 6);
      checkOutput("mp_retire_total", 32'(retireCount - retireStart), 6);

      // Resolve of an empty slot is ignored
      applyStimulus(1'b0, 1'b1, nextTag, 1'b1);
      tick();
      applyStimulus(1'b0, 1'b0, '0, 1'b0);
      repeat (2) tick();
      checkOutput("ignored_resolve_retire", 32'(bus.retire_branch_o), 0);
      checkOutput("ignored_resolve_count", 32'(bus.count_o), 0);

      // Dispatch priority: resolved head waits out three accepts
      baseTag = nextTag;
      applyStimulus(1'b1, 1'b0, '0, 1'b0);
      tick();
      nextTag++;
      applyStimulus(1'b0, 1'b1, baseTag, 1'b0);
      expQ.push_back(1'b0);
      tick();
      applyStimulus(1'b1, 1'b0, '0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("excl_fence", 32'(bus.fence_o), 1);
         checkOutput("excl_no_retire", 32'(bus.retire_branch_o), 0);
      end
      nextTag = nextTag + 3'd3;
      applyStimulus(1'b0, 1'b0, '0, 1'b0);
      tick();
      checkOutput("excl_fence_end", 32'(bus.fence_o), 0);
      checkOutput("excl_retire", 32'(bus.retire_branch_o), 1);
      checkOutput("excl_count", 32'(bus.count_o), 3);

      // Asynchronous reset with four entries pending and a retire due
      applyStimulus(1'b1, 1'b0, '0, 1'b0);
      tick();
      nextTag++;
      applyStimulus(1'b0, 1'b1, baseTag + 3'd1, 1'b0);
      checkOutput("midrst_count_before", 32'(bus.count_o), 4);
      tick();
      applyStimulus(1'b0, 1'b0, '0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      checkResetOutputs("midrst_now");
      repeat (2) tick();
      checkResetOutputs("midrst_hold");
      rst_n = 1'b1;
      repeat (4) tick();
      checkResetOutputs("midrst_after");

      checkOutput("scoreboard_empty", 32'(expQ.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
